// File: rtl/bitwise_check_32.sv
// bitwise_check_32: two-stage streaming checker of 32-bit AND/OR/XOR/NOR results with saturating pass/fail counters.
// Define BITWISE_CHECK_ERRMAP_EN to build the sticky per-bit error map; otherwise err_map is tied to 0.
module bitwise_check_32 #(
  parameter int NUM_VECTORS = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  input  logic [31:0]      c,
  input  logic [1:0]       op,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [97:0]      first_fail,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [31:0]      err_map
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic drain_q, drain_d;
  logic s1_v_q, s1_v_d;
  logic [1:0] s1_op_q;
  logic [31:0] s1_a_q, s1_b_q, s1_c_q;
  logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d;
  logic [97:0] ff_q, ff_d;
  logic seen_q, seen_d;
  logic active, kill, go, accept, cmp, mis;
  logic [31:0] exp_v, diff;
  assign active = (state_q == RUN) || (state_q == DRAIN);
  assign kill = abort && active;
  assign go = start && !abort && ((state_q == IDLE) || (state_q == DONE));
  assign in_ready = state_q == RUN;
  assign accept = in_valid && in_ready && !kill;
  assign exp_v = (s1_op_q == 2'b00) ? (s1_a_q & s1_b_q) :
                 (s1_op_q == 2'b01) ? (s1_a_q | s1_b_q) :
                 (s1_op_q == 2'b10) ? (s1_a_q ^ s1_b_q) : ~(s1_a_q | s1_b_q);
  assign diff = exp_v ^ s1_c_q;
  assign mis = |diff;
  // abort flushes stage 2 as well, so the compare is suppressed on the aborting edge
  assign cmp = s1_v_q && !kill;
  assign busy = active;
  assign done = state_q == DONE;
  assign pass = done && (fail_q == '0);
  assign pass_cnt = pass_q;
  assign fail_cnt = fail_q;
  assign first_fail = ff_q;
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    drain_d = drain_q;
    if (kill) state_d = IDLE;
    else if (go) begin
      state_d = RUN;
      acc_d = '0;
    end else if (accept) begin
      acc_d = acc_q + 16'd1;
      if (acc_q == 16'(NUM_VECTORS - 1)) begin
        state_d = DRAIN;
        drain_d = 1'b0;
      end
    end else if (state_q == DRAIN) begin
      drain_d = 1'b1;
      if (drain_q) state_d = DONE;
    end
  end
  always_comb begin
    s1_v_d = accept;
    pass_d = go ? '0 : (cmp && !mis && pass_q != '1) ? pass_q + 1'b1 : pass_q;
    fail_d = go ? '0 : (cmp && mis && fail_q != '1) ? fail_q + 1'b1 : fail_q;
    ff_d = go ? '0 : (cmp && mis && !seen_q) ? {s1_op_q, s1_a_q, s1_b_q, s1_c_q} : ff_q;
    seen_d = go ? 1'b0 : seen_q | (cmp && mis);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q <= '0;
      drain_q <= 1'b0;
      s1_v_q <= 1'b0;
      s1_op_q <= '0;
      s1_a_q <= '0;
      s1_b_q <= '0;
      s1_c_q <= '0;
      pass_q <= '0;
      fail_q <= '0;
      ff_q <= '0;
      seen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      drain_q <= drain_d;
      s1_v_q <= s1_v_d;
      if (accept) begin
        s1_op_q <= op;
        s1_a_q <= a;
        s1_b_q <= b;
        s1_c_q <= c;
      end
      pass_q <= pass_d;
      fail_q <= fail_d;
      ff_q <= ff_d;
      seen_q <= seen_d;
    end
  end
`ifdef BITWISE_CHECK_ERRMAP_EN
  logic [31:0] err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= '0;
    else err_q <= go ? '0 : cmp ? (err_q | diff) : err_q;
  end
  assign err_map = err_q;
`else
  assign err_map = '0;
`endif
endmodule
